// File: rtl/cfa_pkg.sv
// Shared configuration for the CFA gradient blocks: default widths, the window
// geometry and the loader state encoding.
package cfa_pkg;

    localparam int PIX_W  = 8;
    localparam int WIN    = 5;
    localparam int GRAD_W = 16;
    localparam int NPIX   = WIN * WIN;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a - b|; the result never
// exceeds the operand range, so it keeps the operand width.
module abs_diff #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/grad_hv_accum.sv
// Accumulates horizontal and vertical same-colour gradient sums over one
// WIN x WIN Bayer window that arrives serially in raster order after strat.
module grad_hv_accum
    import cfa_pkg::*;
#(
    parameter int PIX_W  = cfa_pkg::PIX_W,
    parameter int WIN    = cfa_pkg::WIN,
    parameter int GRAD_W = cfa_pkg::GRAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strat,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              busy,
    output logic [GRAD_W-1:0] grad_hs,
    output logic [GRAD_W-1:0] grad_vs,
    output logic              ready
);

    localparam int CNT_W = (WIN > 2) ? $clog2(WIN) : 1;
    localparam int VDEP  = 2 * WIN;
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    // Worst case is every term at full scale; the accumulators must never wrap.
    localparam longint unsigned MAX_SUM =
        longint'(WIN) * longint'(WIN - 2) * ((longint'(1) << PIX_W) - 1);

    generate
        if (WIN < 3) begin : g_win_err
            $error("grad_hv_accum: WIN must be at least 3");
        end
        if (MAX_SUM >= (longint'(1) << GRAD_W)) begin : g_range_err
            $error("grad_hv_accum: GRAD_W too narrow for WIN*(WIN-2)*(2^PIX_W-1)");
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   row;
    logic [CNT_W-1:0]   col;
    logic [GRAD_W-1:0]  acc_h;
    logic [GRAD_W-1:0]  acc_v;
    logic [PIX_W-1:0]   hline [2];
    logic [PIX_W-1:0]   vline [VDEP];

    logic               accept;
    logic               last_pix;
    logic [PIX_W-1:0]   diff_h;
    logic [PIX_W-1:0]   diff_v;
    logic [GRAD_W-1:0]  term_h;
    logic [GRAD_W-1:0]  term_v;
    logic [GRAD_W-1:0]  sum_h;
    logic [GRAD_W-1:0]  sum_v;

    // hline[1] is the pixel two columns back, vline[VDEP-1] two rows back.
    abs_diff #(.W(PIX_W)) u_abs_h (
        .a (pix_in),
        .b (hline[1]),
        .y (diff_h)
    );

    abs_diff #(.W(PIX_W)) u_abs_v (
        .a (pix_in),
        .b (vline[VDEP-1]),
        .y (diff_v)
    );

    assign accept   = (state == LOAD) && pix_valid;
    assign last_pix = (row == CNT_LAST) && (col == CNT_LAST);
    assign term_h   = (col >= CNT_TWO) ? GRAD_W'(diff_h) : '0;
    assign term_v   = (row >= CNT_TWO) ? GRAD_W'(diff_v) : '0;
    assign sum_h    = acc_h + term_h;
    assign sum_v    = acc_v + term_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready   <= 1'b0;
            grad_hs <= '0;
            grad_vs <= '0;
            acc_h   <= '0;
            acc_v   <= '0;
            row     <= '0;
            col     <= '0;
            for (int i = 0; i < 2; i++) hline[i] <= '0;
            for (int i = 0; i < VDEP; i++) vline[i] <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (strat) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        acc_h <= '0;
                        acc_v <= '0;
                        row   <= '0;
                        col   <= '0;
                        for (int i = 0; i < 2; i++) hline[i] <= '0;
                        for (int i = 0; i < VDEP; i++) vline[i] <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        hline[0] <= pix_in;
                        hline[1] <= hline[0];
                        vline[0] <= pix_in;
                        for (int i = 1; i < VDEP; i++) vline[i] <= vline[i-1];
                        if (last_pix) begin
                            grad_hs <= sum_h;
                            grad_vs <= sum_v;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            acc_h <= sum_h;
                            acc_v <= sum_v;
                            if (col == CNT_LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grad_hv_accum.sv
// Directed, table-driven bench for grad_hv_accum: fixed pixel patterns with
// hand-computed gradient sums, plus reset-abort and back-to-back sequences.
module tb_grad_hv_accum;

    localparam int PIX_W  = 8;
    localparam int WIN    = 5;
    localparam int GRAD_W = 16;
    localparam int NPIX   = WIN * WIN;

    logic              clk;
    logic              rst;
    logic              strat;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_in;
    logic              busy;
    logic [GRAD_W-1:0] grad_hs;
    logic [GRAD_W-1:0] grad_vs;
    logic              ready;

    int checks;
    int errors;

    grad_hv_accum dut (
        .clk       (clk),
        .rst       (rst),
        .strat     (strat),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .busy      (busy),
        .grad_hs   (grad_hs),
        .grad_vs   (grad_vs),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pat;
        bit gaps;
        bit noise;
        bit b2b;
        int exp_hs;
        int exp_vs;
    } vec_t;

    // Patterns: 0 flat 100, 1 10*c, 2 10*r, 3 single 255 at (2,2),
    // 4 (r+c) checkerboard, 5/6 255 where c/2 resp. r/2 is even,
    // 7 255 on even columns (same-colour neighbours equal).
    function automatic logic [PIX_W-1:0] pix(input int pat, input int r, input int c);
        case (pat)
            0: return 8'd100;
            1: return 8'(10 * c);
            2: return 8'(10 * r);
            3: return (r == 2 && c == 2) ? 8'd255 : 8'd0;
            4: return ((r + c) % 2 == 0) ? 8'd255 : 8'd0;
            5: return ((c / 2) % 2 == 0) ? 8'd255 : 8'd0;
            6: return ((r / 2) % 2 == 0) ? 8'd255 : 8'd0;
            7: return (c % 2 == 0) ? 8'd255 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start();
        strat = 1'b1;
        @(negedge clk);
        strat = 1'b0;
        check("busy_after_strat", int'(busy), 1);
    endtask

    // Feeds npix pixels; glitch flags any premature ready, busy drop or output change.
    task automatic feed(input int pat, input bit gaps, input bit noise, input int npix,
                        output bit glitch);
        logic [GRAD_W-1:0] hs0;
        logic [GRAD_W-1:0] vs0;
        int stalls;
        glitch = 1'b0;
        hs0 = grad_hs;
        vs0 = grad_vs;
        for (int idx = 0; idx < npix; idx++) begin
            stalls = 0;
            while (gaps && stalls < 6 && $urandom_range(0, 1) == 1) begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom_range(0, 255));
                strat     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                if (ready || !busy || grad_hs != hs0 || grad_vs != vs0) glitch = 1'b1;
                stalls++;
            end
            pix_valid = 1'b1;
            pix_in    = pix(pat, idx / WIN, idx % WIN);
            strat     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (idx != npix - 1 && (ready || !busy || grad_hs != hs0 || grad_vs != vs0))
                glitch = 1'b1;
        end
        pix_valid = 1'b0;
        strat     = 1'b0;
    endtask

    task automatic finish_win(input int exp_hs, input int exp_vs, input bit b2b);
        check("ready_latency", int'(ready), 1);
        check("grad_hs", int'(grad_hs), exp_hs);
        check("grad_vs", int'(grad_vs), exp_vs);
        check("busy_done", int'(busy), 0);
        if (b2b) strat = 1'b1;
        @(negedge clk);
        strat = 1'b0;
        check("ready_one_cycle", int'(ready), 0);
        if (b2b) begin
            check("b2b_busy", int'(busy), 1);
            check("b2b_hold_hs", int'(grad_hs), exp_hs);
        end
    endtask

    vec_t vecs[12];
    bit   glitch;
    bit   bad;
    bit   pending;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        strat     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;

        vecs[0]  = '{pat: 0, gaps: 0, noise: 0, b2b: 0, exp_hs: 0,    exp_vs: 0};
        vecs[1]  = '{pat: 1, gaps: 0, noise: 0, b2b: 0, exp_hs: 300,  exp_vs: 0};
        vecs[2]  = '{pat: 2, gaps: 0, noise: 0, b2b: 1, exp_hs: 0,    exp_vs: 300};
        vecs[3]  = '{pat: 3, gaps: 0, noise: 0, b2b: 0, exp_hs: 510,  exp_vs: 510};
        vecs[4]  = '{pat: 4, gaps: 0, noise: 0, b2b: 0, exp_hs: 0,    exp_vs: 0};
        vecs[5]  = '{pat: 5, gaps: 0, noise: 0, b2b: 0, exp_hs: 3825, exp_vs: 0};
        vecs[6]  = '{pat: 6, gaps: 0, noise: 0, b2b: 0, exp_hs: 0,    exp_vs: 3825};
        vecs[7]  = '{pat: 7, gaps: 0, noise: 0, b2b: 0, exp_hs: 0,    exp_vs: 0};
        vecs[8]  = '{pat: 1, gaps: 1, noise: 1, b2b: 0, exp_hs: 300,  exp_vs: 0};
        vecs[9]  = '{pat: 3, gaps: 1, noise: 1, b2b: 0, exp_hs: 510,  exp_vs: 510};
        vecs[10] = '{pat: 5, gaps: 1, noise: 1, b2b: 1, exp_hs: 3825, exp_vs: 0};
        vecs[11] = '{pat: 2, gaps: 1, noise: 0, b2b: 0, exp_hs: 0,    exp_vs: 300};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_hs", int'(grad_hs), 0);
        check("rst_vs", int'(grad_vs), 0);

        pending = 1'b0;
        for (int v = 0; v < 12; v++) begin
            if (!pending) start();
            feed(vecs[v].pat, vecs[v].gaps, vecs[v].noise, NPIX, glitch);
            check($sformatf("no_glitch_v%0d", v), int'(glitch), 0);
            finish_win(vecs[v].exp_hs, vecs[v].exp_vs, vecs[v].b2b);
            pending = vecs[v].b2b;
        end

        // Abort a window after pixel 12, then feed pixels without strat.
        start();
        feed(3, 0, 0, 13, glitch);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_hs", int'(grad_hs), 0);
        check("abort_vs", int'(grad_vs), 0);
        bad = 1'b0;
        for (int i = 0; i < NPIX + 2; i++) begin
            pix_valid = 1'b1;
            pix_in    = 8'd255;
            @(negedge clk);
            if (busy || ready || grad_hs != 0 || grad_vs != 0) bad = 1'b1;
        end
        pix_valid = 1'b0;
        check("ignored_without_strat", int'(bad), 0);

        start();
        feed(1, 0, 0, NPIX, glitch);
        check("post_abort_no_glitch", int'(glitch), 0);
        finish_win(300, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
